wb_regfile_slave: RTL and testbench
===================================

// Module: wb_regfile_slave
// PURPOSE
//  Parametrised Wishbone B4 register-file slave. Successor to the fixed test slave.
//  Adds configurable width, depth and wait states, byte-lane writes, and an error
//  response for unmapped offsets. Supports registered-feedback incrementing bursts
//  (linear and wrap4/8/16). Sits behind the wb_switch as a memory-mapped target
//  for master BFMs and DSP control.
// PARAMETERS
//  DW          32  data width in bits (8/16/32/64); SW=DW/8 byte lanes
//  AW          32  address width
//  NUM_REGS    16  number of DW-bit registers (1..256); IW=clog2(NUM_REGS)
//  WAIT_STATES 1   extra cycles before first-beat ack (0..15)
//  RESET_VAL   0   reset value of every register
// PORTS
//  wb_clk    in   1   clock
//  wb_rst    in   1   synchronous, active-high reset
//  wb_adr_i  in   AW  byte address; index = adr[LSB+IW-1:LSB], LSB=clog2(SW)
//  wb_dat_i  in   DW  write data
//  wb_sel_i  in   SW  byte enables
//  wb_we_i   in   1   1=write, 0=read
//  wb_cyc_i  in   1   bus cycle valid
//  wb_stb_i  in   1   strobe
//  wb_cti_i  in   3   000 classic, 010 incr burst, 111 end of burst
//  wb_bte_i  in   2   00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//  wb_dat_o  out  DW  read data, valid while wb_ack_o=1
//  wb_ack_o  out  1   normal termination
//  wb_err_o  out  1   error termination (unmapped offset)
//  wb_rty_o  out  1   retry; always 0
// BEHAVIOUR
//  - Reset (wb_rst=1 at a clk edge): state IDLE, all regs=RESET_VAL, wb_dat_o=0,
//    wb_ack_o=0, wb_err_o=0, wb_rty_o=0. Reset wins over any bus activity.
//  - A beat is mapped when adr[AW-1:LSB] < NUM_REGS. Upper bits are not ignored.
//  - FSM IDLE -> WAIT -> BEAT -> (BURST | IDLE):
//    IDLE : cyc&stb -> load cnt=WAIT_STATES and capture index. Go WAIT, or BEAT if 0.
//    WAIT : cnt decrements each cycle. At 0 -> BEAT. If cyc=0 -> IDLE, no access.
//    BEAT : exactly one of ack/err is high this cycle, set by the entering edge.
//    First-beat latency = WAIT_STATES+1 cycles after cyc&stb is first sampled.
//  - The write commits on the edge that raises ack. Per byte lane, reg[i][8k+:8] =
//    dat_i when sel_i[k]. The read value is registered onto dat_o on that same edge.
//  - Unmapped beat: err=1, ack=0, dat_o=0, no register change, cycle ends (-> IDLE).
//  - Acked beat with cti=010 sampled on that edge: go BURST. ack stays high the
//    next cycle, with no wait states. The internal index advances per bte:
//    linear idx+1, or wrapN keeping idx[log2N-1:0] mod N. Upper bits are held.
//    The master must present matching adr. The slave uses its internal index.
//  - BURST continues while cyc&stb&cti=010. On an acked beat with cti=111 or 000,
//    ack drops the next cycle -> IDLE.
//  - Linear advance past NUM_REGS-1: that beat gives err, no write -> IDLE.
//  - cyc or stb low in BURST/BEAT: ack/err low the next cycle -> IDLE. No further
//    writes occur. stb low with cyc high in IDLE: no access.
//  - ack and err are never both 1. Neither is asserted without cyc&stb on the
//    previous edge.
// TESTING
//  1 Write 0x90000000/4/8/C = DEADBEEF,F00DD00F,01234567,89ABCDEF with sel=F,
//    then read back -> identical data, each ack exactly 1 cycle, err=0.
//  2 WAIT_STATES=3: single read -> ack rises exactly 4 cycles after first cyc&stb.
//  3 Write 0x11223344 sel=F, then write 0xAABBCCDD sel=0101 to the same reg.
//    Readback -> 0x11BB33DD.
//  4 NUM_REGS=16: access byte offset 0x40 (index 16) -> err=1 one beat, ack=0,
//    regs unchanged.
//  5 Preload reg i=i. Incr read burst, bte=01, start index 2, 4 beats with cti=111
//    last -> data 2,3,0,1, ack high 4 consecutive cycles after the first, then low.
//  6 Assert wb_rst during beat 2 of a 4-beat write burst -> ack low next cycle.
//    All regs read back RESET_VAL. The next classic write succeeds.

Source files
------------

// File: rtl/wb_regfile_slave.sv
// Wishbone B4 register-file slave.
// Configurable data and address width, register count and first-beat wait states.
// Writes are byte-lane masked, and unmapped offsets end the cycle with an error.
// Registered-feedback incrementing bursts are supported: linear, wrap4, wrap8 and wrap16.
//
// Ports:
//   wb_clk, wb_rst           clock; synchronous active-high reset
//   wb_adr_i                 byte address; word index = adr[LSB+IW-1:LSB]
//   wb_dat_i, wb_sel_i       write data and byte enables
//   wb_we_i                  1 = write, 0 = read
//   wb_cyc_i, wb_stb_i       bus cycle and strobe
//   wb_cti_i, wb_bte_i       cycle type (000 classic, 010 incr, 111 end) and burst type
//   wb_dat_o                 read data, valid while wb_ack_o is high
//   wb_ack_o, wb_err_o       normal and error termination
//   wb_rty_o                 retry, tied low
module wb_regfile_slave #(
    parameter int unsigned   DW          = 32,
    parameter int unsigned   AW          = 32,
    parameter int unsigned   NUM_REGS    = 16,
    parameter int unsigned   WAIT_STATES = 1,
    parameter logic [DW-1:0] RESET_VAL   = '0
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o
);
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned LSB = (SW > 1) ? $clog2(SW) : 0;
    localparam int unsigned IW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StBeat, StBurst} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          map_q, map_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [DW-1:0] regs_q [NUM_REGS];
    logic [DW-1:0] regs_d [NUM_REGS];

    logic          req;
    logic [AW-1:0] adr_word;
    logic          adr_mapped;
    logic [IW:0]   wrap_mask, idx_inc, idx_nxt;
    logic          nxt_mapped;
    logic [3:0]    cnt_dec;
    logic          beat_go, beat_ok;
    logic [IW-1:0] beat_idx;

    assign req        = wb_cyc_i & wb_stb_i;
    // The whole word address is decoded, so aliases above the register file error out.
    assign adr_word   = wb_adr_i >> LSB;
    assign adr_mapped = 64'(adr_word) < 64'(NUM_REGS);

    // Wrapping bursts only advance the low log2(N) index bits; the rest are held.
    always_comb begin
        unique case (wb_bte_i)
            2'b01:   wrap_mask = (IW+1)'(5'h03);
            2'b10:   wrap_mask = (IW+1)'(5'h07);
            2'b11:   wrap_mask = (IW+1)'(5'h0f);
            default: wrap_mask = '1;
        endcase
    end

    assign idx_inc    = {1'b0, idx_q} + (IW+1)'(1);
    assign idx_nxt    = ({1'b0, idx_q} & ~wrap_mask) | (idx_inc & wrap_mask);
    assign nxt_mapped = 64'(idx_nxt) < 64'(NUM_REGS);
    assign cnt_dec    = cnt_q - 4'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        map_d    = map_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = dat_q;
        regs_d   = regs_q;
        beat_go  = 1'b0;
        beat_ok  = 1'b0;
        beat_idx = idx_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    idx_d = wb_adr_i[LSB +: IW];
                    map_d = adr_mapped;
                    cnt_d = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d  = StBeat;
                        beat_go  = 1'b1;
                        beat_idx = wb_adr_i[LSB +: IW];
                        beat_ok  = adr_mapped;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!wb_cyc_i) begin
                    state_d = StIdle;
                end else if (wb_stb_i) begin
                    // Hold the count while stb is low so ack never follows an idle strobe.
                    cnt_d = cnt_dec;
                    if (cnt_dec == 4'd0) begin
                        state_d = StBeat;
                        beat_go = 1'b1;
                        beat_ok = map_q;
                    end
                end
            end
            StBeat, StBurst: begin
                // Only an acked beat may continue; an error beat always ends the cycle.
                if (req && ack_q && wb_cti_i == 3'b010) begin
                    idx_d    = idx_nxt[IW-1:0];
                    beat_go  = 1'b1;
                    beat_idx = idx_nxt[IW-1:0];
                    beat_ok  = nxt_mapped;
                    state_d  = nxt_mapped ? StBurst : StBeat;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // The edge that raises ack commits the write and registers the read data.
        if (beat_go) begin
            if (beat_ok) begin
                ack_d = 1'b1;
                dat_d = regs_q[beat_idx];
                if (wb_we_i) begin
                    for (int unsigned k = 0; k < SW; k++) begin
                        if (wb_sel_i[k]) begin
                            regs_d[beat_idx][8*k +: 8] = wb_dat_i[8*k +: 8];
                        end
                    end
                end
            end else begin
                err_d = 1'b1;
                dat_d = '0;
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            map_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            map_q   <= map_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            regs_q  <= regs_d;
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_regfile_slave.sv
// Bench for wb_regfile_slave: 16 x 32-bit registers, 3 wait states.
// AW is 28 so the top nibble of 0x9000_0xxx (decoded by the switch upstream) never
// reaches the slave.
module tb_wb_regfile_slave;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 28;
    localparam int unsigned NREGS = 16;
    localparam int unsigned WS    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_i;
    logic [3:0]    sel;
    logic          we, cyc, stb;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic [DW-1:0] dat_o;
    logic          ack, err, rty;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [NREGS];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    wb_regfile_slave #(
        .DW(DW), .AW(AW), .NUM_REGS(NREGS), .WAIT_STATES(WS), .RESET_VAL('0)
    ) dut (
        .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty)
    );

    // ack and err must never be high together
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if (ack === 1'b1 && err === 1'b1) begin
                errors++;
                $display("FAIL ack_err_excl: ack=%b err=%b required not both 1", ack, err);
            end
        end
    end

    function automatic void model_write(input int i, input logic [31:0] d, input logic [3:0] s);
        for (int k = 0; k < 4; k++) if (s[k]) model[i][8*k +: 8] = d[8*k +: 8];
    endfunction

    task automatic bus_idle();
        cyc = 0; stb = 0; we = 0; cti = 3'b000; bte = 2'b00; sel = 4'h0; adr = '0; dat_i = '0;
    endtask

    // Classic cycle: drive, wait for ack/err, hold one more cycle to see its width, release.
    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat, output logic got_ack,
                        output logic got_err, output logic [31:0] rd, output logic tail);
        @(negedge clk);
        adr = a; dat_i = d; sel = s; we = w; cti = 3'b000; bte = 2'b00; cyc = 1; stb = 1;
        lat = 0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
        end while (ack !== 1'b1 && err !== 1'b1 && lat < 40);
        got_ack = ack; got_err = err; rd = dat_o;
        @(negedge clk);
        tail = ack | err;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic do_write(input int i, input logic [31:0] d, input logic [3:0] s,
                            input string nm);
        int lat; logic a, e, t; logic [31:0] rd;
        xfer(1'b1, AW'(i * 4), d, s, lat, a, e, rd, t);
        model_write(i, d, s);
        checks++;
        if (a !== 1'b1 || e !== 1'b0 || t !== 1'b0) begin
            errors++;
            $display("FAIL %s: ack=%b err=%b ack_next=%b required 1 0 0", nm, a, e, t);
        end
    endtask

    task automatic do_read(input int i, input string nm);
        int lat; logic a, e, t; logic [31:0] rd, x;
        exp_q.push_back(model[i]);
        xfer(1'b0, AW'(i * 4), '0, 4'hF, lat, a, e, rd, t);
        x = exp_q.pop_front();
        checks++;
        if (a !== 1'b1 || e !== 1'b0 || t !== 1'b0 || rd !== x) begin
            errors++;
            $display("FAIL %s: ack=%b err=%b ack_next=%b data=%h required 1 0 0 %h",
                     nm, a, e, t, rd, x);
        end
    endtask

    task automatic test_reset();
        bus_idle();
        rst = 1;
        @(negedge clk);
        cyc = 1; stb = 1; adr = '0;  // reset must win over a pending request
        repeat (6) @(negedge clk);
        checks++;
        if ({ack, err, rty} !== 3'b000 || dat_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ack/err/rty=%b dat=%h required 000 0",
                     {ack, err, rty}, dat_o);
        end
        bus_idle();
        rst = 0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        do_read(0, "reset_r0");
        do_read(15, "reset_r15");
    endtask

    task automatic test_write_read();
        logic [31:0] base;
        logic [31:0] vals [4];
        int lat; logic a, e, t; logic [31:0] rd, x;
        base = 32'h9000_0000;
        vals[0] = 32'hDEADBEEF; vals[1] = 32'hF00DD00F;
        vals[2] = 32'h01234567; vals[3] = 32'h89ABCDEF;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, AW'(base + 32'(i * 4)), vals[i], 4'hF, lat, a, e, rd, t);
            model_write(i, vals[i], 4'hF);
            checks++;
            if (a !== 1'b1 || e !== 1'b0 || t !== 1'b0) begin
                errors++;
                $display("FAIL wr_word%0d: ack=%b err=%b ack_next=%b required 1 0 0", i, a, e, t);
            end
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(vals[i]);
            xfer(1'b0, AW'(base + 32'(i * 4)), '0, 4'hF, lat, a, e, rd, t);
            x = exp_q.pop_front();
            checks++;
            if (a !== 1'b1 || e !== 1'b0 || t !== 1'b0 || rd !== x) begin
                errors++;
                $display("FAIL rd_word%0d: ack=%b err=%b ack_next=%b data=%h required 1 0 0 %h",
                         i, a, e, t, rd, x);
            end
        end
    endtask

    task automatic test_latency();
        int lat; logic a, e, t; logic [31:0] rd;
        xfer(1'b0, AW'(4), '0, 4'hF, lat, a, e, rd, t);
        checks++;
        if (lat != WS + 1 || a !== 1'b1) begin
            errors++;
            $display("FAIL latency: cycles=%0d ack=%b required %0d 1", lat, a, WS + 1);
        end
        // Abandon a write during the wait states: no ack and no register change.
        @(negedge clk);
        adr = AW'(6 * 4); dat_i = 32'h7777_7777; sel = 4'hF; we = 1; cyc = 1; stb = 1;
        @(negedge clk);
        cyc = 0; stb = 0;
        a = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack === 1'b1 || err === 1'b1) a = 1;
        end
        checks++;
        if (a !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait: termination seen=%b required 0", a);
        end
        bus_idle();
        do_read(6, "abort_r6");
    endtask

    task automatic test_byte_lanes();
        do_write(4, 32'h11223344, 4'hF, "lane_full");
        do_write(4, 32'hAABBCCDD, 4'b0101, "lane_part");
        checks++;
        if (model[4] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL lane_model: value=%h required 11bb33dd", model[4]);
        end
        do_read(4, "lane_rd");
    endtask

    task automatic test_unmapped();
        int lat; logic a, e, t; logic [31:0] rd;
        logic [AW-1:0] bad [2];
        bad[0] = AW'(32'h40);
        bad[1] = AW'(32'h0100_0000);  // upper alias of index 0
        for (int j = 0; j < 2; j++) begin
            xfer(1'b1, bad[j], 32'hFFFF_FFFF, 4'hF, lat, a, e, rd, t);
            checks++;
            if (e !== 1'b1 || a !== 1'b0 || t !== 1'b0 || rd !== 32'h0) begin
                errors++;
                $display("FAIL unmapped_wr%0d: err=%b ack=%b err_next=%b data=%h required 1 0 0 0",
                         j, e, a, t, rd);
            end
            xfer(1'b0, bad[j], '0, 4'hF, lat, a, e, rd, t);
            checks++;
            if (e !== 1'b1 || a !== 1'b0 || rd !== 32'h0) begin
                errors++;
                $display("FAIL unmapped_rd%0d: err=%b ack=%b data=%h required 1 0 0", j, e, a, rd);
            end
        end
        do_read(0, "unmapped_r0");
        do_read(15, "unmapped_r15");
    endtask

    task automatic burst_read(input int start, input logic [1:0] bte_v, input int nb,
                              input string nm);
        int n, waited;
        int idx [16];
        logic [31:0] x;
        n = (bte_v == 2'b00) ? 0 : (2 << bte_v);
        for (int k = 0; k < nb; k++) begin
            idx[k] = (n == 0) ? start + k : (start / n) * n + ((start % n) + k) % n;
            exp_q.push_back(model[idx[k]]);
        end
        @(negedge clk);
        adr = AW'(start * 4); we = 0; sel = 4'hF; bte = bte_v;
        cti = (nb > 1) ? 3'b010 : 3'b111; cyc = 1; stb = 1;
        waited = 0;
        while (ack !== 1'b1 && err !== 1'b1 && waited < 40) begin
            @(negedge clk); waited++;
        end
        for (int k = 0; k < nb; k++) begin
            if (k > 0) @(negedge clk);
            x = exp_q.pop_front();
            checks++;
            if (ack !== 1'b1 || dat_o !== x) begin
                errors++;
                $display("FAIL %s_beat%0d: ack=%b data=%h required 1 %h", nm, k, ack, dat_o, x);
            end
            adr = AW'(idx[k] * 4);
            cti = (k == nb - 1) ? 3'b111 : 3'b010;
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s_end: ack=%b err=%b required 0 0", nm, ack, err);
        end
        bus_idle();
    endtask

    task automatic test_wrap_burst();
        for (int i = 0; i < NREGS; i++) do_write(i, 32'(i), 4'hF, "preload");
        burst_read(2, 2'b01, 4, "wrap4");
        burst_read(13, 2'b10, 8, "wrap8");
        burst_read(5, 2'b00, 3, "linear");
    endtask

    task automatic test_linear_overflow();
        int waited;
        @(negedge clk);
        adr = AW'(14 * 4); we = 0; sel = 4'hF; bte = 2'b00; cti = 3'b010; cyc = 1; stb = 1;
        waited = 0;
        while (ack !== 1'b1 && err !== 1'b1 && waited < 40) begin
            @(negedge clk); waited++;
        end
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (ack !== 1'b1 || dat_o !== model[14 + k]) begin
                errors++;
                $display("FAIL ovf_beat%0d: ack=%b data=%h required 1 %h",
                         k, ack, dat_o, model[14 + k]);
            end
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || ack !== 1'b0 || dat_o !== 32'h0) begin
            errors++;
            $display("FAIL ovf_err: err=%b ack=%b data=%h required 1 0 0", err, ack, dat_o);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL ovf_end: err=%b ack=%b required 0 0", err, ack);
        end
        bus_idle();
    endtask

    task automatic test_reset_in_burst();
        int waited;
        @(negedge clk);
        adr = '0; we = 1; dat_i = 32'h5A5A_5A5A; sel = 4'hF; bte = 2'b00; cti = 3'b010;
        cyc = 1; stb = 1;
        waited = 0;
        while (ack !== 1'b1 && waited < 40) begin
            @(negedge clk); waited++;
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL rstb_beat2: ack=%b required 1", ack);
        end
        rst = 1;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rstb_ack: ack=%b err=%b required 0 0", ack, err);
        end
        bus_idle();
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        for (int i = 0; i < NREGS; i++) do_read(i, "rstb_rd");
        do_write(5, 32'hCAFE_F00D, 4'hF, "rstb_wr");
        do_read(5, "rstb_rd5");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency();
        test_byte_lanes();
        test_unmapped();
        test_wrap_burst();
        test_linear_overflow();
        test_reset_in_burst();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
